// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefNumRegs = 32;
    localparam int unsigned RegZero    = 0;

    function automatic int unsigned addr_w(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for multi-cycle producers; a new issue overrides a
// completing write to the same register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NumRegs = DefNumRegs,
    parameter int unsigned NumRd   = 2,
    parameter int unsigned NumWr   = 2,
    parameter int unsigned ZeroReg = 1,
    parameter int unsigned Aw      = addr_w(NumRegs)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumWr-1:0]      wr_en_i,
    input  logic [NumWr*Aw-1:0]   wr_addr_i,
    input  logic                  busy_set_i,
    input  logic [Aw-1:0]         busy_addr_i,
    input  logic [NumRd*Aw-1:0]   rd_addr_i,
    input  logic [NumRd-1:0]      rd_fwd_i,
    output logic [NumRd-1:0]      rd_busy_o,
    output logic                  busy_any_o
);

    logic [NumRegs-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NumWr; w++) begin
            if (wr_en_i[w]) begin
                busy_d[wr_addr_i[w*Aw +: Aw]] = 1'b0;
            end
        end
        // Set is applied last so it wins over a same-cycle clear.
        if (busy_set_i && !(ZeroReg != 0 && busy_addr_i == Aw'(RegZero))) begin
            busy_d[busy_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy_o = '0;
        for (int unsigned p = 0; p < NumRd; p++) begin
            rd_busy_o[p] = busy_q[rd_addr_i[p*Aw +: Aw]] & ~rd_fwd_i[p];
        end
    end

    assign busy_any_o = |busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with zero register, write-to-read bypass,
// optional registered read and a busy scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned READ_LAT = 0,
    localparam int unsigned AW      = addr_w(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_RD*AW-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*AW-1:0]       wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       busy_set,
    input  logic [AW-1:0]              busy_addr,
    output logic                       busy_any
);

    logic [DATA_W-1:0]        mem_q [NUM_REGS];
    logic [DATA_W-1:0]        mem_d [NUM_REGS];
    logic [NUM_WR-1:0]        wr_ok;
    logic [NUM_RD-1:0]        rd_fwd;
    logic [NUM_RD*DATA_W-1:0] rd_val;

    always_comb begin
        wr_ok = '0;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = wr_en[w] &&
                       !(ZERO_REG != 0 && wr_addr[w*AW +: AW] == AW'(RegZero));
        end
    end

    // Later ports overwrite earlier ones, giving the higher index priority.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w]) begin
                mem_d[wr_addr[w*AW +: AW]] = wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_fwd = '0;
        rd_val = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            if (!(ZERO_REG != 0 && rd_addr[p*AW +: AW] == AW'(RegZero))) begin
                rd_val[p*DATA_W +: DATA_W] = mem_q[rd_addr[p*AW +: AW]];
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (BYPASS != 0 && wr_ok[w] &&
                        wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]) begin
                        rd_fwd[p]                  = 1'b1;
                        rd_val[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    if (READ_LAT != 0) begin : g_rd_reg
        logic [NUM_RD*DATA_W-1:0] rd_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_val;
            end
        end

        assign rd_data = rd_q;
    end else begin : g_rd_comb
        // Bypassed write data must not leak out while reset is held.
        assign rd_data = reset_n ? rd_val : '0;
    end

    rf_scoreboard #(
        .NumRegs (NUM_REGS),
        .NumRd   (NUM_RD),
        .NumWr   (NUM_WR),
        .ZeroReg (ZERO_REG),
        .Aw      (AW)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .busy_set_i  (busy_set),
        .busy_addr_i (busy_addr),
        .rd_addr_i   (rd_addr),
        .rd_fwd_i    (rd_fwd),
        .rd_busy_o   (rd_busy),
        .busy_any_o  (busy_any)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed table plus random model check for reg_file_mp in three configurations.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the 32x32 2R/2W instances (A: comb read, B: registered read).
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [9:0]  rd_addr = '0;
    logic        busy_set = 1'b0;
    logic [4:0]  busy_addr = '0;
    logic [63:0] a_rd_data, b_rd_data;
    logic [1:0]  a_rd_busy, b_rd_busy;
    logic        a_busy_any, b_busy_any;

    // 16x64 4R/1W instance (C).
    logic [0:0]   c_wr_en = '0;
    logic [3:0]   c_wr_addr = '0;
    logic [63:0]  c_wr_data = '0;
    logic [15:0]  c_rd_addr = '0;
    logic         c_busy_set = 1'b0;
    logic [3:0]   c_busy_addr = '0;
    logic [255:0] c_rd_data;
    logic [3:0]   c_rd_busy;
    logic         c_busy_any;

    reg_file_mp #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
        .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_any(a_busy_any)
    );

    reg_file_mp #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
        .ZERO_REG(1), .BYPASS(1), .READ_LAT(1)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_any(b_busy_any)
    );

    reg_file_mp #(
        .DATA_W(64), .NUM_REGS(16), .NUM_RD(4), .NUM_WR(1),
        .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)
    ) u_c (
        .clk(clk), .reset_n(reset_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .busy_set(c_busy_set), .busy_addr(c_busy_addr), .busy_any(c_busy_any)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic        bs;
        logic [4:0]  ba;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
        logic        eany;
    } vec_t;

    function automatic vec_t v(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                               input logic [31:0] wd0, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic bs, input logic [4:0] ba,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [1:0] eb, input logic eany);
        vec_t r;
        r.we = we; r.wa0 = wa0; r.wa1 = wa1; r.wd0 = wd0; r.wd1 = wd1;
        r.ra0 = ra0; r.ra1 = ra1; r.bs = bs; r.ba = ba;
        r.e0 = e0; r.e1 = e1; r.eb = eb; r.eany = eany;
        return r;
    endfunction

    vec_t vt[16];
    logic [63:0] m [16];
    logic [15:0] mb;

    initial begin
        logic [31:0] pe0, pe1;
        logic [3:0]  a;
        logic        hit;
        logic [63:0] ed;
        logic [3:0]  eb4;

        // ---- reset ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_data", a_rd_data, 64'h0);
        chk("rst_a_busy", {62'h0, a_rd_busy}, 64'h0);
        chk("rst_a_any", {63'h0, a_busy_any}, 64'h0);
        chk("rst_b_data", b_rd_data, 64'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            rd_addr = {5'(31 - i), 5'(i)};
            @(negedge clk);
            chk($sformatf("rst_r%0d_p0", i), {32'h0, a_rd_data[31:0]}, 64'h0);
            chk($sformatf("rst_r%0d_p1", 31 - i), {32'h0, a_rd_data[63:32]}, 64'h0);
        end
        @(posedge clk); #1;
        rd_addr = '0;

        // ---- directed table ----
        vt[0]  = v(2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 5'd5, 5'd5, 1'b0, 5'd0,
                   32'h22, 32'h22, 2'b00, 1'b0);
        vt[1]  = v(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0,
                   32'h22, 32'h0, 2'b00, 1'b0);
        vt[2]  = v(2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 5'd0, 5'd5, 1'b1, 5'd0,
                   32'h0, 32'h22, 2'b00, 1'b0);
        vt[3]  = v(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd7,
                   32'h0, 32'h0, 2'b00, 1'b0);
        vt[4]  = v(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0,
                   32'h0, 32'h0, 2'b11, 1'b1);
        vt[5]  = v(2'b10, 5'd0, 5'd7, 32'h0, 32'hAA, 5'd7, 5'd5, 1'b0, 5'd0,
                   32'hAA, 32'h22, 2'b00, 1'b1);
        vt[6]  = v(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0,
                   32'hAA, 32'hAA, 2'b00, 1'b0);
        vt[7]  = v(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd3, 1'b1, 5'd7,
                   32'hAA, 32'h0, 2'b00, 1'b0);
        vt[8]  = v(2'b01, 5'd7, 5'd0, 32'hBB, 32'h0, 5'd7, 5'd7, 1'b1, 5'd7,
                   32'hBB, 32'hBB, 2'b00, 1'b1);
        vt[9]  = v(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0,
                   32'hBB, 32'hBB, 2'b11, 1'b1);
        vt[10] = v(2'b11, 5'd3, 5'd9, 32'h55, 32'h99, 5'd3, 5'd9, 1'b0, 5'd0,
                   32'h55, 32'h99, 2'b00, 1'b1);
        vt[11] = v(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd7, 1'b0, 5'd0,
                   32'h55, 32'hBB, 2'b10, 1'b1);
        vt[12] = v(2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 5'd7, 5'd3, 1'b0, 5'd0,
                   32'h77, 32'h55, 2'b00, 1'b1);
        vt[13] = v(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd9, 1'b0, 5'd0,
                   32'h77, 32'h99, 2'b00, 1'b0);
        vt[14] = v(2'b11, 5'd31, 5'd1, 32'hDEADBEEF, 32'h1, 5'd31, 5'd1, 1'b0, 5'd0,
                   32'hDEADBEEF, 32'h1, 2'b00, 1'b0);
        vt[15] = v(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd1, 1'b0, 5'd0,
                   32'hDEADBEEF, 32'h1, 2'b00, 1'b0);

        pe0 = 32'h0;
        pe1 = 32'h0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            wr_en     = vt[i].we;
            wr_addr   = {vt[i].wa1, vt[i].wa0};
            wr_data   = {vt[i].wd1, vt[i].wd0};
            rd_addr   = {vt[i].ra1, vt[i].ra0};
            busy_set  = vt[i].bs;
            busy_addr = vt[i].ba;
            @(negedge clk);
            chk($sformatf("v%0d_a_rd0", i), {32'h0, a_rd_data[31:0]}, {32'h0, vt[i].e0});
            chk($sformatf("v%0d_a_rd1", i), {32'h0, a_rd_data[63:32]}, {32'h0, vt[i].e1});
            chk($sformatf("v%0d_a_busy", i), {62'h0, a_rd_busy}, {62'h0, vt[i].eb});
            chk($sformatf("v%0d_a_any", i), {63'h0, a_busy_any}, {63'h0, vt[i].eany});
            chk($sformatf("v%0d_b_rd0", i), {32'h0, b_rd_data[31:0]}, {32'h0, pe0});
            chk($sformatf("v%0d_b_rd1", i), {32'h0, b_rd_data[63:32]}, {32'h0, pe1});
            chk($sformatf("v%0d_b_busy", i), {62'h0, b_rd_busy}, {62'h0, vt[i].eb});
            pe0 = vt[i].e0;
            pe1 = vt[i].e1;
        end

        // ---- reset asserted mid-cycle with a write and busy_set pending ----
        @(posedge clk); #1;
        wr_en     = 2'b01;
        wr_addr   = {5'd0, 5'd31};
        wr_data   = {32'h0, 32'hCAFEF00D};
        busy_set  = 1'b1;
        busy_addr = 5'd31;
        rd_addr   = {5'd7, 5'd31};
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_a_rd0", {32'h0, a_rd_data[31:0]}, 64'h0);
        chk("mid_a_rd1", {32'h0, a_rd_data[63:32]}, 64'h0);
        chk("mid_a_any", {63'h0, a_busy_any}, 64'h0);
        chk("mid_a_busy", {62'h0, a_rd_busy}, 64'h0);
        chk("mid_b_rd", b_rd_data, 64'h0);
        @(posedge clk); #1;
        wr_en    = 2'b00;
        busy_set = 1'b0;
        reset_n  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            rd_addr = {5'(i), 5'(31 - i)};
            @(negedge clk);
            chk($sformatf("post_r%0d", 31 - i), {32'h0, a_rd_data[31:0]}, 64'h0);
            chk("post_busy", {62'h0, a_rd_busy}, 64'h0);
            chk("post_any", {63'h0, a_busy_any}, 64'h0);
        end

        // ---- random sequence on the 16x64 4R/1W instance ----
        for (int i = 0; i < 16; i++) m[i] = 64'h0;
        mb = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk); #1;
            c_wr_en     = 1'($urandom_range(0, 1));
            c_wr_addr   = 4'($urandom_range(0, 15));
            c_wr_data   = {$urandom, $urandom};
            c_busy_set  = ($urandom_range(0, 3) == 0);
            c_busy_addr = 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++) begin
                c_rd_addr[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? c_wr_addr
                                                                    : 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            eb4 = '0;
            for (int p = 0; p < 4; p++) begin
                a   = c_rd_addr[p*4 +: 4];
                hit = c_wr_en[0] && (c_wr_addr == a) && (a != 4'd0);
                ed  = (a == 4'd0) ? 64'h0 : (hit ? c_wr_data : m[a]);
                eb4[p] = mb[a] && !hit;
                chk($sformatf("c%0d_rd%0d", cyc, p), c_rd_data[p*64 +: 64], ed);
            end
            chk($sformatf("c%0d_busy", cyc), {60'h0, c_rd_busy}, {60'h0, eb4});
            chk($sformatf("c%0d_any", cyc), {63'h0, c_busy_any}, {63'h0, |mb});
            if (c_wr_en[0] && c_wr_addr != 4'd0) begin
                m[c_wr_addr] = c_wr_data;
            end
            if (c_wr_en[0]) mb[c_wr_addr] = 1'b0;
            if (c_busy_set && c_busy_addr != 4'd0) mb[c_busy_addr] = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
